// File: rtl/bus_rsp_delay_filter_pkg.sv
// Shared types and helpers for the response delay filter.
//   rsp_entry_t : one queued response {rdata, err, host_sel, cnt}. The fields
//                 are sized for the widest supported configuration. Each
//                 instance zero-extends its narrower fields on the way in and
//                 truncates them on the way out, so unused upper bits are
//                 constant and are pruned away.
//   MaxDelay    : largest supported extra delay for memory responses.
//   cnt_init    : starting countdown for a response, chosen by responding device.
package bus_delay_pkg;

   localparam int unsigned MaxDelay     = 63;
   localparam int          MaxCntWidth  = $clog2(MaxDelay + 1);
   localparam int          MaxDataWidth = 64;
   localparam int          MaxSelWidth  = 8;

   typedef struct packed {
      logic [MaxDataWidth-1:0] rdata;
      logic                    err;
      logic [MaxSelWidth-1:0]  host_sel;
      logic [MaxCntWidth-1:0]  cnt;
   } rsp_entry_t;

   // Memory (device 0) waits the full delay; every other device waits nothing.
   // An out-of-range delay is clamped to MaxDelay.
   function automatic logic [MaxCntWidth-1:0] cnt_init(input int unsigned device_sel,
                                                        input int unsigned delay);
      int unsigned d;
      d = delay;
      if (d > MaxDelay) begin
         d = MaxDelay;
      end
      if (device_sel != 0) begin
         d = 0;
      end
      return MaxCntWidth'(d);
   endfunction

endpackage

// File: rtl/bus_rsp_delay_filter_fifo.sv
// Register-array response queue with a per-entry saturating countdown.
//   clk, rst_n  : clock, asynchronous active-low reset (empties the queue)
//   push        : write push_entry at the tail (ignored when full and not popping)
//   push_entry  : entry to store, cnt already initialised
//   pop         : remove the head (ignored unless head_ready)
//   head        : current head entry
//   head_ready  : queue not empty and head countdown reached zero
//   count       : number of stored entries, 0..Depth
module bus_rsp_delay_fifo
   import bus_delay_pkg::*;
#(
   parameter int Depth = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  rsp_entry_t               push_entry,
   input  logic                     pop,
   output rsp_entry_t               head,
   output logic                     head_ready,
   output logic [$clog2(Depth):0]   count
);

   localparam int PtrW = $clog2(Depth);

   rsp_entry_t            mem_q [Depth];
   logic [PtrW-1:0]       rd_ptr;
   logic [PtrW-1:0]       wr_ptr;
   logic [PtrW:0]         count_q;
   logic                  empty;
   logic                  full;
   logic                  do_pop;
   logic                  do_push;

   assign empty      = (count_q == '0);
   assign full       = (count_q == (PtrW + 1)'(Depth));
   assign head       = mem_q[rd_ptr];
   assign head_ready = !empty && (head.cnt == '0);
   assign do_pop     = pop && head_ready;
   // A pop in the same cycle frees the slot the push needs.
   assign do_push    = push && (!full || do_pop);
   assign count      = count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PtrW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PtrW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + (PtrW + 1)'(1);
            2'b01:   count_q <= count_q - (PtrW + 1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Every slot counts down each cycle; free slots hold don't-care values, so
   // they are decremented too. A write in the same cycle overrides the
   // decrement, so a fresh entry starts from its full count.
   always_ff @(posedge clk) begin
      for (int i = 0; i < Depth; i++) begin
         if (mem_q[i].cnt != '0) begin
            mem_q[i].cnt <= mem_q[i].cnt - MaxCntWidth'(1);
         end
      end
      if (do_push) begin
         mem_q[wr_ptr] <= push_entry;
      end
   end

endmodule

// File: rtl/bus_rsp_delay_filter.sv
// Response delay filter for latency-stress simulation. Memory responses
// (device_sel_i == 0) are held for Delay extra cycles, peripheral responses
// pass with the minimum one-cycle latency, and all responses leave in arrival
// order.
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   dev_rvalid_i         : device response valid (at most one per cycle)
//   dev_rdata_i          : device read data
//   dev_err_i            : device error flag
//   host_sel_i           : host the response belongs to
//   device_sel_i         : responding device, 0 = memory
//   host_rvalid_o        : delayed response valid
//   host_rdata_o         : delayed read data (0 when not valid)
//   host_err_o           : delayed error flag (0 when not valid)
//   host_sel_o           : routing tag for the host demux (0 when not valid)
//   full_o               : queue holds Depth entries
//   overflow_o           : sticky, a response was dropped since reset
module bus_rsp_delay_filter
   import bus_delay_pkg::*;
#(
   parameter int Delay            = 1,
   parameter int Depth            = 4,
   parameter int DataWidth        = 32,
   parameter int NrHosts          = 1,
   parameter int NrDevices        = 1,
   parameter int NumBitsHostSel   = (NrHosts > 1) ? $clog2(NrHosts) : 1,
   parameter int NumBitsDeviceSel = (NrDevices > 1) ? $clog2(NrDevices) : 1
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        dev_rvalid_i,
   input  logic [DataWidth-1:0]        dev_rdata_i,
   input  logic                        dev_err_i,
   input  logic [NumBitsHostSel-1:0]   host_sel_i,
   input  logic [NumBitsDeviceSel-1:0] device_sel_i,
   output logic                        host_rvalid_o,
   output logic [DataWidth-1:0]        host_rdata_o,
   output logic                        host_err_o,
   output logic [NumBitsHostSel-1:0]   host_sel_o,
   output logic                        full_o,
   output logic                        overflow_o
);

   localparam int PtrW = $clog2(Depth);

   rsp_entry_t                push_entry;
   rsp_entry_t                head;
   logic                      head_ready;
   logic                      push;
   logic                      full;
   logic [PtrW:0]             count;
   logic                      overflow_q;
   logic                      vld_p1;
   logic [DataWidth-1:0]      rdata_p1;
   logic                      err_p1;
   logic [NumBitsHostSel-1:0] host_sel_p1;
   // The countdown field of the head is consumed inside the queue only.
   logic                      unused_head;

   always_comb begin
      push_entry          = '0;
      push_entry.rdata    = MaxDataWidth'(dev_rdata_i);
      push_entry.err      = dev_err_i;
      push_entry.host_sel = MaxSelWidth'(host_sel_i);
      push_entry.cnt      = cnt_init(32'(device_sel_i), Delay);
   end

   assign full = (count == (PtrW + 1)'(Depth));
   assign push = dev_rvalid_i && (!full || head_ready);

   bus_rsp_delay_fifo #(
      .Depth      (Depth)
   ) u_fifo (
      .clk        (clk_i),
      .rst_n      (rst_ni),
      .push       (push),
      .push_entry (push_entry),
      .pop        (head_ready),
      .head       (head),
      .head_ready (head_ready),
      .count      (count)
   );

   assign unused_head = ^head;

   // A response arriving while full with nothing leaving is lost; remember it.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         overflow_q <= 1'b0;
      end else if (dev_rvalid_i && full && !head_ready) begin
         overflow_q <= 1'b1;
      end
   end

   // ---- stage p1: registered output of the popped head ----
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         vld_p1      <= 1'b0;
         rdata_p1    <= '0;
         err_p1      <= 1'b0;
         host_sel_p1 <= '0;
      end else begin
         vld_p1 <= head_ready;
         if (head_ready) begin
            rdata_p1    <= DataWidth'(head.rdata);
            err_p1      <= head.err;
            host_sel_p1 <= NumBitsHostSel'(head.host_sel);
         end else begin
            rdata_p1    <= '0;
            err_p1      <= 1'b0;
            host_sel_p1 <= '0;
         end
      end
   end

   assign host_rvalid_o = vld_p1;
   assign host_rdata_o  = rdata_p1;
   assign host_err_o    = err_p1;
   assign host_sel_o    = host_sel_p1;
   assign full_o        = full;
   assign overflow_o    = overflow_q;

endmodule

// File: tb/tb_bus_rsp_delay_filter.sv
// Directed bench for bus_rsp_delay_filter. Three instances share the input
// stimulus: A (Delay=3), B (Delay=8), C (Delay=0), all Depth=4.
module tb_bus_rsp_delay_filter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rvalid;
   logic [31:0] rdata;
   logic        err;
   logic [0:0]  hsel;
   logic [0:0]  dsel;

   logic        a_vld, a_err, a_full, a_ovf;
   logic [31:0] a_rdata;
   logic [0:0]  a_sel;
   logic        b_vld, b_err, b_full, b_ovf;
   logic [31:0] b_rdata;
   logic [0:0]  b_sel;
   logic        c_vld, c_err, c_full, c_ovf;
   logic [31:0] c_rdata;
   logic [0:0]  c_sel;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bus_rsp_delay_filter #(.Delay(3), .Depth(4), .DataWidth(32), .NrHosts(2), .NrDevices(2)) u_a (
      .clk_i(clk), .rst_ni(rst_n), .dev_rvalid_i(rvalid), .dev_rdata_i(rdata), .dev_err_i(err),
      .host_sel_i(hsel), .device_sel_i(dsel), .host_rvalid_o(a_vld), .host_rdata_o(a_rdata),
      .host_err_o(a_err), .host_sel_o(a_sel), .full_o(a_full), .overflow_o(a_ovf));

   bus_rsp_delay_filter #(.Delay(8), .Depth(4), .DataWidth(32), .NrHosts(2), .NrDevices(2)) u_b (
      .clk_i(clk), .rst_ni(rst_n), .dev_rvalid_i(rvalid), .dev_rdata_i(rdata), .dev_err_i(err),
      .host_sel_i(hsel), .device_sel_i(dsel), .host_rvalid_o(b_vld), .host_rdata_o(b_rdata),
      .host_err_o(b_err), .host_sel_o(b_sel), .full_o(b_full), .overflow_o(b_ovf));

   bus_rsp_delay_filter #(.Delay(0), .Depth(4), .DataWidth(32), .NrHosts(2), .NrDevices(2)) u_c (
      .clk_i(clk), .rst_ni(rst_n), .dev_rvalid_i(rvalid), .dev_rdata_i(rdata), .dev_err_i(err),
      .host_sel_i(hsel), .device_sel_i(dsel), .host_rvalid_o(c_vld), .host_rdata_o(c_rdata),
      .host_err_o(c_err), .host_sel_o(c_sel), .full_o(c_full), .overflow_o(c_ovf));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] d, input logic e,
                        input logic h, input logic ds);
      rvalid = v;
      rdata  = d;
      err    = e;
      hsel   = h;
      dsel   = ds;
   endtask

   task automatic idle();
      drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic apply_reset();
      idle();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      idle();
      rst_n = 1'b0;
      #1;
      checks++;
      if (a_vld !== 1'b0 || a_rdata !== 32'h0 || a_err !== 1'b0 || a_sel !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs got vld=%0b rdata=%h err=%0b sel=%0b want all 0",
                  a_vld, a_rdata, a_err, a_sel);
      end
      checks++;
      if (a_full !== 1'b0 || a_ovf !== 1'b0 || b_ovf !== 1'b0 || c_vld !== 1'b0) begin
         errors++;
         $display("FAIL reset_flags got a_full=%0b a_ovf=%0b b_ovf=%0b c_vld=%0b want 0",
                  a_full, a_ovf, b_ovf, c_vld);
      end
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   // Memory response pushed at edge 0 leaves at edge 4 (Delay+1).
   task automatic test_mem_delay();
      logic        ev;
      logic [31:0] ed;
      apply_reset();
      drive(1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0);
      tick();
      idle();
      for (int k = 1; k <= 6; k++) begin
         tick();
         ev = (k == 4);
         ed = (k == 4) ? 32'hDEADBEEF : 32'h0;
         checks++;
         if (a_vld !== ev || a_rdata !== ed || a_sel !== 1'(ev)) begin
            errors++;
            $display("FAIL mem_delay k=%0d got vld=%0b rdata=%h sel=%0b want vld=%0b rdata=%h sel=%0b",
                     k, a_vld, a_rdata, a_sel, ev, ed, ev);
         end
      end
   endtask

   // Peripheral response on an empty queue leaves one edge later.
   task automatic test_periph();
      logic        ev;
      logic [31:0] ed;
      apply_reset();
      drive(1'b1, 32'h12345678, 1'b1, 1'b0, 1'b1);
      tick();
      idle();
      for (int k = 1; k <= 3; k++) begin
         tick();
         ev = (k == 1);
         ed = (k == 1) ? 32'h12345678 : 32'h0;
         checks++;
         if (a_vld !== ev || a_rdata !== ed || a_err !== ev) begin
            errors++;
            $display("FAIL periph k=%0d got vld=%0b rdata=%h err=%0b want vld=%0b rdata=%h err=%0b",
                     k, a_vld, a_rdata, a_err, ev, ed, ev);
         end
      end
   endtask

   // Memory at edge 0, peripheral at edge 1: memory out at 4, peripheral at 5.
   task automatic test_order();
      logic        ev, ee;
      logic [31:0] ed;
      apply_reset();
      drive(1'b1, 32'hAAAA0001, 1'b0, 1'b0, 1'b0);
      tick();
      for (int k = 1; k <= 7; k++) begin
         if (k == 1) drive(1'b1, 32'hBBBB0002, 1'b1, 1'b1, 1'b1);
         else        idle();
         tick();
         ev = (k == 4) || (k == 5);
         ee = (k == 5);
         ed = (k == 4) ? 32'hAAAA0001 : (k == 5) ? 32'hBBBB0002 : 32'h0;
         checks++;
         if (a_vld !== ev || a_rdata !== ed || a_err !== ee || a_sel !== 1'(ee)) begin
            errors++;
            $display("FAIL order k=%0d got vld=%0b rdata=%h err=%0b sel=%0b want vld=%0b rdata=%h err=%0b sel=%0b",
                     k, a_vld, a_rdata, a_err, a_sel, ev, ed, ee, ee);
         end
      end
   endtask

   // Delay=8, Depth=4: five back-to-back pushes, the fifth is dropped.
   task automatic test_overflow();
      logic        ev;
      logic [31:0] ed;
      int          j;
      apply_reset();
      for (int i = 0; i < 5; i++) begin
         j = i;
         drive(1'b1, (i == 4) ? 32'hBAD0BAD0 : (32'hA0000000 + 32'(i)), 1'b0, j[0], 1'b0);
         tick();
         if (i == 2) begin
            checks++;
            if (b_full !== 1'b0 || b_ovf !== 1'b0) begin
               errors++;
               $display("FAIL ovf_three got full=%0b ovf=%0b want 0 0", b_full, b_ovf);
            end
         end
         if (i == 3) begin
            checks++;
            if (b_full !== 1'b1 || b_ovf !== 1'b0) begin
               errors++;
               $display("FAIL ovf_four got full=%0b ovf=%0b want 1 0", b_full, b_ovf);
            end
         end
         if (i == 4) begin
            checks++;
            if (b_full !== 1'b1 || b_ovf !== 1'b1) begin
               errors++;
               $display("FAIL ovf_five got full=%0b ovf=%0b want 1 1", b_full, b_ovf);
            end
         end
      end
      idle();
      for (int k = 5; k <= 14; k++) begin
         tick();
         ev = (k >= 9) && (k <= 12);
         ed = ev ? (32'hA0000000 + 32'(k - 9)) : 32'h0;
         checks++;
         if (b_vld !== ev || b_rdata !== ed || b_ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_drain k=%0d got vld=%0b rdata=%h ovf=%0b want vld=%0b rdata=%h ovf=1",
                     k, b_vld, b_rdata, b_ovf, ev, ed);
         end
      end
      checks++;
      if (b_full !== 1'b0) begin
         errors++;
         $display("FAIL ovf_empty got full=%0b want 0", b_full);
      end
   endtask

   // Delay=0: 20-cycle stream with alternating err comes out one edge later.
   task automatic test_back_to_back();
      logic        ev, ee, es;
      logic [31:0] ed;
      int          j;
      apply_reset();
      for (int i = 0; i <= 21; i++) begin
         j = i;
         if (i < 20) drive(1'b1, 32'h5A000000 + 32'(i * 7), j[0], j[1], j[2]);
         else        idle();
         tick();
         j = i - 1;
         ev = (i >= 1) && (i <= 20);
         ed = ev ? (32'h5A000000 + 32'(j * 7)) : 32'h0;
         ee = ev ? j[0] : 1'b0;
         es = ev ? j[1] : 1'b0;
         checks++;
         if (c_vld !== ev || c_rdata !== ed || c_err !== ee || c_sel !== es) begin
            errors++;
            $display("FAIL stream i=%0d got vld=%0b rdata=%h err=%0b sel=%0b want vld=%0b rdata=%h err=%0b sel=%0b",
                     i, c_vld, c_rdata, c_err, c_sel, ev, ed, ee, es);
         end
      end
      checks++;
      if (c_ovf !== 1'b0 || c_full !== 1'b0) begin
         errors++;
         $display("FAIL stream_flags got ovf=%0b full=%0b want 0 0", c_ovf, c_full);
      end
   endtask

   // Reset while one response is on the output and three are still queued.
   task automatic test_reset_mid();
      apply_reset();
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, 32'hC0000000 + 32'(k), 1'b0, 1'b1, 1'b0);
         tick();
      end
      idle();
      checks++;
      if (a_full !== 1'b1) begin
         errors++;
         $display("FAIL mid_full got %0b want 1", a_full);
      end
      tick();
      checks++;
      if (a_vld !== 1'b1 || a_rdata !== 32'hC0000000) begin
         errors++;
         $display("FAIL mid_first got vld=%0b rdata=%h want vld=1 rdata=c0000000", a_vld, a_rdata);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (a_vld !== 1'b0 || a_rdata !== 32'h0 || a_sel !== 1'b0 || a_full !== 1'b0) begin
         errors++;
         $display("FAIL mid_async got vld=%0b rdata=%h sel=%0b full=%0b want all 0",
                  a_vld, a_rdata, a_sel, a_full);
      end
      #1;
      rst_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         tick();
         checks++;
         if (a_vld !== 1'b0 || a_rdata !== 32'h0 || a_full !== 1'b0) begin
            errors++;
            $display("FAIL mid_stale k=%0d got vld=%0b rdata=%h full=%0b want 0 0 0",
                     k, a_vld, a_rdata, a_full);
         end
      end
   endtask

   initial begin
      idle();
      rst_n = 1'b1;
      test_reset();
      test_mem_delay();
      test_periph();
      test_order();
      test_overflow();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
